// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: shares one I2C write engine between NREQ requesters with round-robin
// grant and NACK retry. Define I2C_ARB_TIMEOUT_EN to add a watchdog on the engine wait.
module i2c_cmd_arbiter #(
    parameter int NREQ        = 3,
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic [NREQ-1:0]      iREQ,
    input  logic [24*NREQ-1:0]   iREQ_DATA,
    output logic [NREQ-1:0]      oGNT,
    output logic [NREQ-1:0]      oDONE,
    output logic [NREQ-1:0]      oERR,
    output logic                 oBUSY,
    output logic [23:0]          oENG_DATA,
    output logic                 oENG_GO,
    input  logic                 iENG_END,
    input  logic                 iENG_ACK
);

    // state   | meaning
    // IDLE    | no transaction, scanning requests from rr_ptr
    // ISSUE   | grant and command latched, raising GO
    // WAIT    | GO held until the engine reports END
    // RELEASE | waiting for END to fall, then retry or finish
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic [23:0]       data_q, data_d;
    logic              go_q, go_d;
    logic [3:0]        retry_cnt_q, retry_cnt_d;
    logic              retry_flag_q, retry_flag_d;
    logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]   widx_q, widx_d;

    logic [NREQ-1:0]   win_onehot;
    logic [IDXW-1:0]   win_idx;
    logic [23:0]       win_data;
    int                scan_j;
    logic              timeout;

    // Scan offsets from the highest down so the closest requester after rr_ptr wins last.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_data   = '0;
        scan_j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_j = int'(rr_ptr_q) + k;
            if (scan_j >= NREQ) begin
                scan_j = scan_j - NREQ;
            end
            for (int m = 0; m < NREQ; m++) begin
                if (m == scan_j && iREQ[m]) begin
                    win_onehot    = '0;
                    win_onehot[m] = 1'b1;
                    win_idx       = IDXW'(m);
                    win_data      = iREQ_DATA[24*m +: 24];
                end
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] wdog_q;

    // Down-counter loaded in ISSUE; terminal count in WAIT means the engine never answered.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            wdog_q <= '0;
        end else if (state_q == ISSUE) begin
            wdog_q <= 16'(TIMEOUT_CYC - 1);
        end else if (state_q == WAIT && wdog_q != '0) begin
            wdog_q <= wdog_q - 16'd1;
        end
    end

    assign timeout = (state_q == WAIT) && !iENG_END && (wdog_q == '0);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
            data_q       <= '0;
            go_q         <= 1'b0;
            retry_cnt_q  <= '0;
            retry_flag_q <= 1'b0;
            rr_ptr_q     <= '0;
            widx_q       <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            data_q       <= data_d;
            go_q         <= go_d;
            retry_cnt_q  <= retry_cnt_d;
            retry_flag_q <= retry_flag_d;
            rr_ptr_q     <= rr_ptr_d;
            widx_q       <= widx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|iREQ) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (iENG_END || timeout) state_d = RELEASE;
            RELEASE: if (!iENG_END) state_d = retry_flag_q ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d        = gnt_q;
        done_d       = '0;
        err_d        = '0;
        data_d       = data_q;
        go_d         = go_q;
        retry_cnt_d  = retry_cnt_q;
        retry_flag_d = retry_flag_q;
        rr_ptr_d     = rr_ptr_q;
        widx_d       = widx_q;
        case (state_q)
            IDLE: begin
                if (|iREQ) begin
                    gnt_d        = win_onehot;
                    data_d       = win_data;
                    widx_d       = win_idx;
                    retry_cnt_d  = '0;
                    retry_flag_d = 1'b0;
                end
            end
            ISSUE: go_d = 1'b1;
            WAIT: begin
                if (iENG_END) begin
                    go_d = 1'b0;
                    if (!iENG_ACK) begin
                        done_d = gnt_q;
                    end else if (retry_cnt_q < 4'(MAX_RETRY)) begin
                        retry_cnt_d  = retry_cnt_q + 4'd1;
                        retry_flag_d = 1'b1;
                    end else begin
                        err_d = gnt_q;
                    end
                end else if (timeout) begin
                    go_d  = 1'b0;
                    err_d = gnt_q;
                end
            end
            RELEASE: begin
                if (!iENG_END) begin
                    if (retry_flag_q) begin
                        retry_flag_d = 1'b0;
                    end else begin
                        gnt_d    = '0;
                        rr_ptr_d = (widx_q == IDXW'(NREQ - 1)) ? '0 : widx_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign oGNT      = gnt_q;
    assign oDONE     = done_q;
    assign oERR      = err_q;
    assign oBUSY     = (state_q != IDLE);
    assign oENG_DATA = data_q;
    assign oENG_GO   = go_q;

endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
Shares one I2C write-transaction engine (24-bit {slave_addr, sub_addr, data} command, GO/END/ACK handshake) between several configuration requesters. Typical requesters: boot-time codec LUT sequencer, runtime volume control, video-decoder setup. Provides round-robin arbitration, NACK retry and per-requester completion/error reporting. Sits between the requesters and the I2C engine in the board-level audio/video config path.

Parameters:
NREQ, 3, number of requesters (2..8)
MAX_RETRY, 2, retries after a NACK before reporting error (0..15)
TIMEOUT_CYC, 65535, watchdog limit in iCLK cycles (used only with I2C_ARB_TIMEOUT_EN)

Ports:
iCLK  in  1  system clock; all logic on rising edge
iRST_N  in  1  synchronous active-low reset
iREQ  in  NREQ  per-requester request level
iREQ_DATA  in  24*NREQ  command per requester; slice i = bits [24*i+23:24*i]
oGNT  out  NREQ  one-hot grant, held for the whole transaction including retries
oDONE  out  NREQ  1-cycle pulse: transaction ACKed
oERR  out  NREQ  1-cycle pulse: retries exhausted or timeout
oBUSY  out  1  high in every state except IDLE
oENG_DATA  out  24  command to engine, registered at grant
oENG_GO  out  1  engine start level
iENG_END  in  1  engine completion level
iENG_ACK  in  1  engine status, valid while iENG_END=1; 1 = NACK/failure

Behaviour:
- Reset (iRST_N=0 at a rising edge): state=IDLE; oGNT=0, oDONE=0, oERR=0, oBUSY=0, oENG_GO=0, oENG_DATA=0; retry_cnt=0; rr_ptr=0 (requester 0 has highest priority first).
- States: IDLE, ISSUE, WAIT, RELEASE.
- IDLE: if iREQ!=0, select winner = first set bit scanning rr_ptr, rr_ptr+1, ... mod NREQ. Next edge: oGNT[w]=1, oENG_DATA=slice w, retry_cnt=0, state=ISSUE.
- ISSUE: oENG_GO<=1; state=WAIT.
- WAIT: hold oENG_GO=1 until iENG_END=1. On that edge: oENG_GO<=0.
  - iENG_ACK=0: oDONE[w]=1 for 1 cycle.
  - iENG_ACK=1 and retry_cnt<MAX_RETRY: retry_cnt+1, set retry flag; no pulse.
  - Otherwise: oERR[w]=1 for 1 cycle.
  - In all cases state=RELEASE.
- RELEASE: wait for iENG_END=0.
  - Retry flag set: clear it, state=ISSUE. oENG_DATA and oGNT unchanged.
  - Else: oGNT=0, rr_ptr=(w+1) mod NREQ, state=IDLE.
- Minimum gap from oDONE to the next grant: 2 cycles (RELEASE, then IDLE).
- Requester contract: hold iREQ and its data stable until its oDONE/oERR. If iREQ is still high when the arbiter returns to IDLE, it is treated as a new request.
- iREQ dropped mid-transaction: ignored; the transaction completes and reports normally.
- iREQ_DATA changed after grant: no effect, since the command was latched at grant.
- Simultaneous requests: round-robin guarantees each active requester is served within NREQ transactions.
- Reset mid-transaction: all outputs return to reset values on that edge, including immediate drop of oENG_GO. The engine must tolerate GO being released.
- oDONE and oERR are never high together; at most one bit of oDONE|oERR is set per cycle.

Optional Feature:
- Macro I2C_ARB_TIMEOUT_EN.
- Defined: a 16-bit watchdog clears on entering ISSUE and counts every cycle in WAIT. If it reaches TIMEOUT_CYC with iENG_END still 0: oENG_GO<=0, oERR[w] pulses, no retry, state=RELEASE. The normal iENG_END=0 exit then returns to IDLE.
- Not defined: no counter; WAIT can last indefinitely.

Test Plan:
- Single request: iREQ=3'b001, data 24'h34_1201; engine ENDs with ACK=0 after 10 cycles -> oGNT=001 throughout, oENG_DATA=341201, one oDONE[0] pulse, oBUSY returns to 0.
- Round-robin: iREQ=3'b111 held, each requester dropping its REQ after its DONE -> grant order 0,1,2. Second burst with rr_ptr=1 -> order 1,2,0.
- NACK retry: engine returns ACK=1 twice, then 0 (MAX_RETRY=2) -> exactly 3 GO assertions, same oENG_DATA each time, single oDONE, no oERR.
- Retry exhaustion: ACK=1 on every attempt -> 3 GO assertions, then one oERR pulse on the granted requester, no oDONE.
- Reset mid-WAIT: assert iRST_N=0 while oENG_GO=1 -> next edge oENG_GO=0, oGNT=0, state IDLE. After release, a pending request is granted to requester 0.
- Timeout (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYC=100): iENG_END held 0 -> oENG_GO drops 100 cycles after entering WAIT, oERR pulses, arbiter returns to IDLE.
